// File: rtl/tx_framer_pkg.sv
// Shared types and helpers for tx_packet_framer.
// The state enum covers the optional CRC states, which are only reachable when
// TX_PACKET_FRAMER_CRC8_EN is defined.
package tx_framer_pkg;

   // Frame sequencing states; CRC_HI/CRC_LO are only visited in CRC builds
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      NIBBLE = 3'd1,
      CRC_HI = 3'd2,
      CRC_LO = 3'd3,
      TERM   = 3'd4
   } state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // Upper-case ASCII hex digit for one nibble
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] r_ascii;
      if (nib < 4'd10) r_ascii = 8'h30 + {4'h0, nib};
      else             r_ascii = 8'h37 + {4'h0, nib};
      return r_ascii;
   endfunction

   // One byte of CRC-8 (MSB-first, no reflection, no final xor)
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] r_c;
      r_c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (r_c[7]) r_c = (r_c << 1) ^ CRC8_POLY;
         else        r_c = r_c << 1;
      end
      return r_c;
   endfunction

endpackage

// File: rtl/tx_packet_framer.sv
// tx_packet_framer: serialises a PACKET_SIZE-bit snapshot as upper-case ASCII hex,
// most significant nibble first, followed by TERMINATOR, on a valid/ready byte
// stream. frame_count counts frames whose terminator has been consumed.
// Optional feature: define TX_PACKET_FRAMER_CRC8_EN to append two ASCII hex bytes
// of a CRC-8 over the hex bytes before the terminator.
module tx_packet_framer
   import tx_framer_pkg::*;
#(
   parameter int         PACKET_SIZE = 256,
   parameter logic [7:0] TERMINATOR  = 8'h0D,
   parameter int         CNT_WIDTH   = 16
) (
   input  logic                   intclk,
   input  logic                   rst_n,
   input  logic [PACKET_SIZE-1:0] pkt_data,
   input  logic                   pkt_valid,
   output logic                   pkt_ready,
   output logic [7:0]             tx_byte,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   frame_count
);

   localparam int NIBBLES = PACKET_SIZE / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   // Registered state
   state_e                 r_state;
   logic [PACKET_SIZE-1:0] r_shadow;
   logic [IDX_W-1:0]       r_idx;
   logic [7:0]             r_tx_byte;
   logic                   r_tx_valid;
   logic [CNT_WIDTH-1:0]   r_frame_count;

   // Next-state values
   state_e                 w_state_nxt;
   logic [PACKET_SIZE-1:0] w_shadow_nxt;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic [7:0]             w_tx_byte_nxt;
   logic                   w_tx_valid_nxt;
   logic [CNT_WIDTH-1:0]   w_frame_count_nxt;

   // Handshakes and derived data
   logic                   w_accept;
   logic                   w_tx_hs;
   logic [PACKET_SIZE-1:0] w_shadow_shl;
   logic [7:0]             w_first_ascii;
   logic [7:0]             w_next_ascii;

   // The shadow register is shifted left one nibble per sent digit, so the
   // digit to send next is always in the top nibble regardless of PACKET_SIZE.
   assign w_accept      = pkt_valid && (r_state == IDLE);
   assign w_tx_hs       = r_tx_valid && tx_ready;
   assign w_shadow_shl  = r_shadow << 4;
   assign w_first_ascii = hex_ascii(pkt_data[PACKET_SIZE-1 -: 4]);
   assign w_next_ascii  = hex_ascii(w_shadow_shl[PACKET_SIZE-1 -: 4]);

`ifdef TX_PACKET_FRAMER_CRC8_EN
   logic [7:0] r_crc;
   logic [7:0] w_crc_next;

   // CRC including the hex byte currently being handed over
   assign w_crc_next = crc8_step(r_crc, r_tx_byte);

   // CRC accumulates over the hex digits only; the CRC bytes themselves are not folded in
   always_ff @(posedge intclk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= 8'h00;
      end else if (w_accept) begin
         r_crc <= 8'h00;
      end else if ((r_state == NIBBLE) && w_tx_hs) begin
         r_crc <= w_crc_next;
      end
   end
`endif

   // Next-state decode: each handshake registers the following byte so transfers run back to back
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that leaves one unassigned infers a latch.
      w_state_nxt       = r_state;
      w_shadow_nxt      = r_shadow;
      w_idx_nxt         = r_idx;
      w_tx_byte_nxt     = r_tx_byte;
      w_tx_valid_nxt    = r_tx_valid;
      w_frame_count_nxt = r_frame_count;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt    = NIBBLE;
               w_shadow_nxt   = pkt_data;
               w_idx_nxt      = IDX_LAST;
               w_tx_byte_nxt  = w_first_ascii;
               w_tx_valid_nxt = 1'b1;
            end
         end

         NIBBLE: begin
            if (w_tx_hs) begin
               if (r_idx == '0) begin
`ifdef TX_PACKET_FRAMER_CRC8_EN
                  w_state_nxt   = CRC_HI;
                  w_tx_byte_nxt = hex_ascii(w_crc_next[7:4]);
`else
                  w_state_nxt   = TERM;
                  w_tx_byte_nxt = TERMINATOR;
`endif
               end else begin
                  w_idx_nxt     = r_idx - IDX_W'(1);
                  w_shadow_nxt  = w_shadow_shl;
                  w_tx_byte_nxt = w_next_ascii;
               end
            end
         end

`ifdef TX_PACKET_FRAMER_CRC8_EN
         CRC_HI: begin
            // r_crc now holds the final CRC, updated on the last digit's handshake
            if (w_tx_hs) begin
               w_state_nxt   = CRC_LO;
               w_tx_byte_nxt = hex_ascii(r_crc[3:0]);
            end
         end

         CRC_LO: begin
            if (w_tx_hs) begin
               w_state_nxt   = TERM;
               w_tx_byte_nxt = TERMINATOR;
            end
         end
`endif

         TERM: begin
            if (w_tx_hs) begin
               w_state_nxt       = IDLE;
               w_tx_valid_nxt    = 1'b0;
               w_tx_byte_nxt     = 8'h00;
               w_frame_count_nxt = r_frame_count + CNT_WIDTH'(1);
            end
         end

         default: begin
            w_state_nxt    = IDLE;
            w_tx_valid_nxt = 1'b0;
            w_tx_byte_nxt  = 8'h00;
         end
      endcase
   end

   // State registers; reset aborts any frame in flight
   always_ff @(posedge intclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_shadow      <= '0;
         r_idx         <= '0;
         r_tx_byte     <= 8'h00;
         r_tx_valid    <= 1'b0;
         r_frame_count <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values.
         r_state       <= w_state_nxt;
         r_shadow      <= w_shadow_nxt;
         r_idx         <= w_idx_nxt;
         r_tx_byte     <= w_tx_byte_nxt;
         r_tx_valid    <= w_tx_valid_nxt;
         r_frame_count <= w_frame_count_nxt;
      end
   end

   assign pkt_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign tx_byte     = r_tx_byte;
   assign tx_valid    = r_tx_valid;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_tx_packet_framer.sv
// Self-checking bench for tx_packet_framer (PACKET_SIZE=8, CNT_WIDTH=2).
// A queue-based model predicts the byte stream of each accepted snapshot and the
// handshake-visible status; it honours TX_PACKET_FRAMER_CRC8_EN when defined.
module tb_tx_packet_framer;

   localparam int         PS     = 8;
   localparam int         CW     = 2;
   localparam int         NIB    = PS / 4;
   localparam logic [7:0] TERM_B = 8'h0D;
`ifdef TX_PACKET_FRAMER_CRC8_EN
   localparam int FL = NIB + 3;
`else
   localparam int FL = NIB + 1;
`endif

   logic          intclk = 1'b0;
   logic          rst_n = 1'b0;
   logic [PS-1:0] pkt_data = '0;
   logic          pkt_valid = 1'b0;
   logic          pkt_ready;
   logic [7:0]    tx_byte;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic          busy;
   logic [CW-1:0] frame_count;

   tx_packet_framer #(
      .PACKET_SIZE(PS),
      .TERMINATOR (TERM_B),
      .CNT_WIDTH  (CW)
   ) dut (
      .intclk     (intclk),
      .rst_n      (rst_n),
      .pkt_data   (pkt_data),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .frame_count(frame_count)
   );

   always #5 intclk = ~intclk;

   typedef struct {
      logic [7:0] b;
      bit         last;
   } exp_t;

   exp_t       exp_q[$];
   bit         in_frame = 0;
   int         exp_frames = 0;
   int         n_accept = 0;
   int         cyc = 0;
   logic [7:0] seen[$];
   int         hs_cyc[$];
   int         acc_cyc[$];
   int         total = 0;
   int         bad = 0;
   int         ready_mode = 3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] hex_char(input int v);
      return (v < 10) ? 8'(48 + v) : 8'(55 + v);
   endfunction

   // Bit-serial CRC-8, poly 0x07, init 0
   function automatic logic [7:0] crc8_of(input logic [7:0] bytes[$]);
      logic [7:0] c = 8'h00;
      foreach (bytes[k]) begin
         for (int b = 7; b >= 0; b--) begin
            logic fb;
            fb = c[7] ^ bytes[k][b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return c;
   endfunction

   task automatic push_frame(input logic [PS-1:0] d);
      logic [7:0] bytes[$];
      for (int i = NIB - 1; i >= 0; i--)
         bytes.push_back(hex_char(int'((d >> (4 * i)) & PS'(15))));
`ifdef TX_PACKET_FRAMER_CRC8_EN
      begin
         logic [7:0] c;
         c = crc8_of(bytes);
         bytes.push_back(hex_char(int'(c[7:4])));
         bytes.push_back(hex_char(int'(c[3:0])));
      end
`endif
      bytes.push_back(TERM_B);
      foreach (bytes[k]) begin
         exp_t e;
         e.b    = bytes[k];
         e.last = (k == bytes.size() - 1);
         exp_q.push_back(e);
      end
   endtask

   always @(posedge intclk) cyc++;

   // tx_ready driver: 0 always ready, 1 toggling, 2 random, other stalled
   always @(posedge intclk) begin
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         2:       tx_ready = 1'($urandom_range(0, 1));
         default: tx_ready = 1'b0;
      endcase
   end

   // Compare process: check outputs mid-cycle, then advance the model for the coming edge
   always @(negedge intclk) begin
      if (!rst_n) begin
         exp_q.delete();
         in_frame   = 0;
         exp_frames = 0;
         check("rst_tx_valid", tx_valid, 0);
         check("rst_tx_byte", tx_byte, 0);
         check("rst_pkt_ready", pkt_ready, 1);
         check("rst_busy", busy, 0);
         check("rst_frame_count", frame_count, 0);
      end else begin
         check("busy", busy, in_frame);
         check("pkt_ready", pkt_ready, !in_frame);
         check("tx_valid", tx_valid, in_frame);
         check("frame_count", frame_count, exp_frames % (1 << CW));
         if (in_frame) check("tx_byte", tx_byte, exp_q[0].b);
         if (!in_frame && pkt_valid) begin
            push_frame(pkt_data);
            in_frame = 1;
            n_accept++;
            acc_cyc.push_back(cyc);
         end else if (in_frame && tx_ready) begin
            seen.push_back(tx_byte);
            hs_cyc.push_back(cyc);
            if (exp_q[0].last) begin
               in_frame = 0;
               exp_frames++;
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_accept(input int start);
      for (int n = 0; n < 300 && n_accept == start; n++) begin
         @(posedge intclk);
         #1;
      end
      check("accept_timeout", n_accept - start, 1);
   endtask

   task automatic send_frame(input logic [PS-1:0] d);
      int start;
      start = n_accept;
      @(posedge intclk);
      #1;
      pkt_data  = d;
      pkt_valid = 1'b1;
      wait_accept(start);
      pkt_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(posedge intclk);
         #2;
         n++;
      end while (in_frame && n < 300);
      check("idle_timeout", in_frame, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [CW-1:0] wrap_seq[5];
      logic [PS-1:0] wrap_data[5];
      int            start;
      wrap_seq  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      wrap_data = '{8'h5B, 8'h00, 8'hFF, 8'h9A, 8'h0F};

`ifdef TX_PACKET_FRAMER_CRC8_EN
      begin
         logic [7:0] s[$];
         s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
         check("crc_model_pin", crc8_of(s), 8'hF4);
      end
`endif

      // Reset
      repeat (3) @(posedge intclk);
      #1 rst_n = 1'b1;
      ready_mode = 0;

      // Single frame at full rate: "3A" then terminator on consecutive cycles
      seen.delete(); hs_cyc.delete(); acc_cyc.delete();
      send_frame(8'h3A);
      wait_idle();
      check("t1_len", seen.size(), FL);
      check("t1_b0", seen[0], 8'h33);
      check("t1_b1", seen[1], 8'h41);
      check("t1_term", seen[FL-1], 8'h0D);
      check("t1_latency", hs_cyc[0] - acc_cyc[0], 1);
      for (int i = 1; i < FL; i++) check("t1_back_to_back", hs_cyc[i] - hs_cyc[i-1], 1);
      check("t1_count", frame_count, 1);
      check("t1_ready_back", pkt_ready, 1);

      // Toggling tx_ready: bytes held while stalled, no duplicates or skips
      ready_mode = 1;
      seen.delete(); hs_cyc.delete();
      send_frame(8'h3A);
      wait_idle();
      check("t3_len", seen.size(), FL);
      check("t3_b0", seen[0], 8'h33);
      check("t3_b1", seen[1], 8'h41);
      check("t3_term", seen[FL-1], 8'h0D);
      check("t3_stall_gap", hs_cyc[1] - hs_cyc[0], 2);

      // pkt_valid held across two frames, data changed mid-frame
      ready_mode = 0;
      seen.delete(); hs_cyc.delete(); acc_cyc.delete();
      @(posedge intclk);
      #1;
      start     = n_accept;
      pkt_data  = 8'hC5;
      pkt_valid = 1'b1;
      wait_accept(start);
      pkt_data  = 8'h7E;
      wait_accept(start + 1);
      pkt_valid = 1'b0;
      wait_idle();
      check("t4_len", seen.size(), 2 * FL);
      check("t4_f1_b0", seen[0], 8'h43);
      check("t4_f1_b1", seen[1], 8'h35);
      check("t4_f2_b0", seen[FL], 8'h37);
      check("t4_f2_b1", seen[FL+1], 8'h45);
      check("t4_next_accept", acc_cyc[1] - hs_cyc[FL-1], 1);
      check("t4_count", frame_count, 0);

      // Asynchronous reset while the first nibble is stalled
      ready_mode = 3;
      send_frame(8'hA7);
      @(posedge intclk);
      @(posedge intclk);
      #3 rst_n = 1'b0;
      #1;
      check("t5_tx_valid", tx_valid, 0);
      check("t5_pkt_ready", pkt_ready, 1);
      check("t5_busy", busy, 0);
      check("t5_count", frame_count, 0);
      @(posedge intclk);
      #1 rst_n = 1'b1;

      // Five frames after reset: counter wraps 1,2,3,0,1
      ready_mode = 0;
      for (int k = 0; k < 5; k++) begin
         seen.delete();
         send_frame(wrap_data[k]);
         wait_idle();
         check("t6_count", frame_count, wrap_seq[k]);
         if (k == 0) check("t5_msb_first", seen[0], 8'h35);
      end

      // Randomised traffic: random data, random back-pressure, sends issued while busy
      ready_mode = 2;
      for (int k = 0; k < 40; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge intclk);
         send_frame(PS'($urandom));
      end
      wait_idle();
      check("rand_frames", frame_count, exp_frames % (1 << CW));

      ready_mode = 0;
      repeat (3) @(posedge intclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
